dma_rc_tag_collect: RTL
=======================

// Module: dma_rc_tag_collect
// PURPOSE
//  Completion collector on the read path. Takes CplD TLPs returned for DMA memory-read requests.
//  Writes each payload into the per-tag slot of the shared completion RAM.
//  Counts received DW per tag against the length expected at request issue.
//  When a tag is complete, pulses tag_rc_vld/tag_rc_number/tag_rc_len to the tag manager, which then schedules RAM readout.
// PARAMETERS
//  TAG_W    5    tag number width (32 tags)
//  DATA_W   128  completion data / RAM word width, bits (DW_PER_BEAT = DATA_W/32)
//  SLOT_DW  128  RAM slot size per tag in DW (512 B max read request)
//  AW       TAG_W+$clog2(SLOT_DW/DW_PER_BEAT)  RAM word address width (local)
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        reset, asynchronous, active-low
//  exp_vld       in   1        request issued: arm tag exp_tag
//  exp_tag       in   TAG_W    tag being armed
//  exp_len       in   11       expected total DW for that tag, 1..SLOT_DW
//  cpl_valid     in   1        completion beat valid
//  cpl_ready     out  1        beat accepted when valid&ready
//  cpl_sop       in   1        first beat of TLP; header fields valid
//  cpl_eop       in   1        last beat of TLP
//  cpl_tag       in   TAG_W    completion tag (sampled at sop)
//  cpl_len       in   10       payload DW of this TLP, 0 = 1024 (sampled at sop)
//  cpl_status    in   3        completion status, 3'b000 = SC (sampled at sop)
//  cpl_data      in   DATA_W   payload, DW0 in bits [31:0]
//  ram_we        out  1        RAM write strobe
//  ram_addr      out  AW       {tag, word offset}
//  ram_wdata     out  DATA_W   write data
//  ram_be        out  DATA_W/32 per-DW write enable
//  tag_rc_vld    out  1        one-cycle pulse: tag fully written
//  tag_rc_number out  TAG_W    completed tag
//  tag_rc_len    out  11       total DW written for that tag
//  err_vld/err_tag out 1/TAG_W  only with DMA_RC_ERR_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - All outputs 0, cpl_ready 0, all per-tag armed bits and rcv_cnt 0, FSM IDLE.
//  - cpl_ready rises the first clk after rst_n deasserts and stays 1.
//  - Reset mid-TLP discards partial data; no tag_rc_vld is issued for it.
//  Per-tag state: armed[t], exp[t] (11b), rcv_cnt[t] (11b). exp_vld sets armed, loads exp, clears rcv_cnt.
//  FSM:
//  - IDLE -(sop beat accepted)-> DATA, or DROP if tag not armed.
//  - DATA: on eop -> IDLE.
//  - DROP: data discarded, no RAM write; on eop -> IDLE.
//  - A sop&eop beat (single-beat TLP) returns to IDLE in the same cycle.
//  Per accepted beat in DATA:
//  - n = min(DW_PER_BEAT, TLP DW remaining); ram_be = low n bits set.
//  - ram_addr = {tag, rcv_cnt[t]/DW_PER_BEAT}; rcv_cnt[t] += n.
//  - Upstream guarantees intermediate completions end on DW_PER_BEAT boundaries (RCB 64 B).
//  Latency:
//  - RAM write registered, 1 clk after beat acceptance.
//  - tag_rc_vld 1 clk after the final RAM write of the tag (data already in RAM).
//  Completion: rcv_cnt[t]==exp[t] at a TLP eop -> pulse, tag_rc_len=exp[t], armed[t] cleared.
//  Overflow: rcv_cnt+n > exp[t] -> excess DW not written (be masked), armed[t] cleared; no tag_rc_vld.
//  Simultaneous events:
//  - exp_vld for tag t and a beat for the same t: beat uses old state, then exp_vld wins.
//  - Otherwise independent. One beat/clk, so at most one tag_rc_vld per clk.
//  Tags may complete out of order; the tag manager restores order.
// CONFIGURATION
//  DMA_RC_ERR_EN defined:
//  - cpl_status != SC at sop -> DROP, armed[t] cleared.
//  - err_vld pulses 1 clk after eop with err_tag=t; overflow also flags err.
//  - Unarmed-tag completions flag err_vld with err_tag=cpl_tag.
//  DMA_RC_ERR_EN undefined:
//  - cpl_status is ignored; non-SC data is written as SC.
//  - err ports are absent; overflow and unarmed cases are silently dropped.
// TESTING
//  1. exp tag3 len 16; one CplD tag3 len16 (4 beats) -> 4 writes addr {3,0..3} be 4'hF; tag_rc_vld, tag_rc_number 3, tag_rc_len 16 one clk later.
//  2. exp tag7 len 128; four CplD len 32 each -> 32 writes, offsets 0..31 contiguous; single tag_rc_vld after 4th eop only.
//  3. exp tag1 len 6; CplD len 6 -> 2 writes, be 4'hF then 4'h3; tag_rc_len 6.
//  4. tags 2 and 5 armed; complete 5 then 2 -> tag_rc_vld for 5 then 2; no cross-slot writes.
//  5. CplD to unarmed tag 9 -> no ram_we, no tag_rc_vld; with DMA_RC_ERR_EN err_vld, err_tag 9; status CA likewise.
//  6. rst_n low mid-TLP, then exp+full CplD tag3 -> outputs 0 during reset; clean completion afterwards, no stale pulse.

Source files
------------

// File: rtl/dma_rc_tag_collect_if.sv
// Completion beat stream into the read-completion collector.
// master drives the CplD beats; slave is the collector.
interface dma_rc_tag_collect_if #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 128
);
    logic              cpl_valid;
    logic              cpl_ready;
    logic              cpl_sop;
    logic              cpl_eop;
    logic [TAG_W-1:0]  cpl_tag;
    logic [9:0]        cpl_len;
    logic [2:0]        cpl_status;
    logic [DATA_W-1:0] cpl_data;

    modport master (
        output cpl_valid, cpl_sop, cpl_eop, cpl_tag,
        output cpl_len, cpl_status, cpl_data,
        input  cpl_ready
    );

    modport slave (
        input  cpl_valid, cpl_sop, cpl_eop, cpl_tag,
        input  cpl_len, cpl_status, cpl_data,
        output cpl_ready
    );
endinterface

// File: rtl/dma_rc_tag_collect.sv
// Read-completion collector: stores CplD payload in per-tag RAM slots and
// reports fully received tags. Optional error reporting: DMA_RC_ERR_EN.
module dma_rc_tag_collect #(
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 128,
    parameter int SLOT_DW = 128,
    localparam int DPB    = DATA_W / 32,
    localparam int OFF_W  = $clog2(SLOT_DW / DPB),
    localparam int AW     = TAG_W + OFF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exp_vld,
    input  logic [TAG_W-1:0]  exp_tag,
    input  logic [10:0]       exp_len,
    dma_rc_tag_collect_if.slave cpl,
    output logic              ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DPB-1:0]    ram_be,
    output logic              tag_rc_vld,
    output logic [TAG_W-1:0]  tag_rc_number,
    output logic [10:0]       tag_rc_len
`ifdef DMA_RC_ERR_EN
    ,
    output logic              err_vld,
    output logic [TAG_W-1:0]  err_tag
`endif
);
    localparam int NTAG = 2 ** TAG_W;
    localparam int SH   = $clog2(DPB);

    typedef enum logic [1:0] {IDLE, DATA, DROP} st_t;

    st_t st, st_n;

    logic [NTAG-1:0]  armed;
    logic [10:0]      exp_q [NTAG];
    logic [10:0]      rcv_cnt [NTAG];
    logic [TAG_W-1:0] cur_tag;
    logic [10:0]      rem_q;

    logic             acc, start, active, wr_path, bad;
    logic             ovf, done;
    logic [TAG_W-1:0] tg;
    logic [10:0]      len_dec, remv, n, cnt, ex, allow;
    logic [11:0]      sum;
    logic [DPB-1:0]   be_c;

    logic             done_q;
    logic [TAG_W-1:0] done_tag;
    logic [10:0]      done_len;

    assign acc     = cpl.cpl_valid && cpl.cpl_ready;
    assign len_dec = (cpl.cpl_len == 10'd0) ? 11'd1024
                                            : {1'b0, cpl.cpl_len};

`ifdef DMA_RC_ERR_EN
    assign bad = (cpl.cpl_status != 3'b000);
`else
    assign bad = 1'b0;
    logic unused_status;
    assign unused_status = ^cpl.cpl_status;
`endif

    always_comb begin
        start   = acc && (st == IDLE) && cpl.cpl_sop;
        active  = acc && (start || (st != IDLE));
        tg      = start ? cpl.cpl_tag : cur_tag;
        remv    = start ? len_dec : rem_q;
        wr_path = acc && (start ? (armed[cpl.cpl_tag] && !bad)
                                : (st == DATA));
        n       = (remv < 11'(DPB)) ? remv : 11'(DPB);
        cnt     = rcv_cnt[tg];
        ex      = exp_q[tg];
        sum     = {1'b0, cnt} + {1'b0, n};
        ovf     = wr_path && (sum > {1'b0, ex});
        allow   = n;
        if (ovf) begin
            allow = (cnt < ex) ? (ex - cnt) : 11'd0;
        end
        done = wr_path && cpl.cpl_eop && !ovf && armed[tg]
            && (sum == {1'b0, ex});
        for (int i = 0; i < DPB; i++) begin
            be_c[i] = (11'(i) < allow);
        end
    end

    // A non-written TLP parks in DROP until its eop
    always_comb begin
        st_n = st;
        case (st)
            IDLE: begin
                if (start && !cpl.cpl_eop) begin
                    st_n = (wr_path && !ovf) ? DATA : DROP;
                end
            end
            DATA: begin
                if (acc) begin
                    if (cpl.cpl_eop)  st_n = IDLE;
                    else if (ovf)     st_n = DROP;
                end
            end
            DROP: begin
                if (acc && cpl.cpl_eop) st_n = IDLE;
            end
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= IDLE;
            cpl.cpl_ready <= 1'b0;
            cur_tag       <= '0;
            rem_q         <= '0;
        end else begin
            st            <= st_n;
            cpl.cpl_ready <= 1'b1;
            if (active) begin
                cur_tag <= tg;
                rem_q   <= remv - n;
            end
        end
    end

    // Beat updates first; a same-cycle exp_vld re-arm overrides them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= '0;
            for (int t = 0; t < NTAG; t++) begin
                exp_q[t]   <= '0;
                rcv_cnt[t] <= '0;
            end
        end else begin
            if (wr_path) begin
                rcv_cnt[tg] <= cnt + allow;
            end
            if (ovf || done) begin
                armed[tg] <= 1'b0;
            end
            if (start && bad) begin
                armed[cpl.cpl_tag] <= 1'b0;
            end
            if (exp_vld) begin
                armed[exp_tag]   <= 1'b1;
                exp_q[exp_tag]   <= exp_len;
                rcv_cnt[exp_tag] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            ram_be        <= '0;
            done_q        <= 1'b0;
            done_tag      <= '0;
            done_len      <= '0;
            tag_rc_vld    <= 1'b0;
            tag_rc_number <= '0;
            tag_rc_len    <= '0;
        end else begin
            ram_we        <= wr_path && (allow != 11'd0);
            ram_addr      <= {tg, cnt[SH +: OFF_W]};
            ram_wdata     <= cpl.cpl_data;
            ram_be        <= be_c;
            done_q        <= done;
            done_tag      <= tg;
            done_len      <= ex;
            tag_rc_vld    <= done_q;
            tag_rc_number <= done_tag;
            tag_rc_len    <= done_len;
        end
    end

`ifdef DMA_RC_ERR_EN
    logic err_q, err_now, err_any;

    assign err_now = active
        && ((start && !(armed[cpl.cpl_tag] && !bad)) || ovf);
    assign err_any = err_now || (!start && err_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            err_vld <= 1'b0;
            err_tag <= '0;
        end else begin
            err_vld <= 1'b0;
            if (active) begin
                if (cpl.cpl_eop) begin
                    err_vld <= err_any;
                    err_tag <= tg;
                    err_q   <= 1'b0;
                end else begin
                    err_q <= err_any;
                end
            end
        end
    end
`endif
endmodule
